// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI driver arbiter
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int DEFAULT_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    DONE,
    ERR
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin priority select
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Lowest requester at or above ptr wins; if none, lowest requester below ptr (wrap).
  // The second loop overrides the first, and each loop runs downward so the lowest index lands last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i < int'(ptr))) begin
        winner = IDX_W'(i);
        valid  = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) begin
        winner = IDX_W'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin sharing of one SPI driver between byte requesters
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*SPI_BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  output logic [SPI_BYTE_W-1:0]         rx_data,
  output logic [NUM_REQ-1:0]            cs_n,
  output logic                          drv_start,
  output logic [SPI_BYTE_W-1:0]         drv_data_in,
  input  logic                          drv_en,
  input  logic [SPI_BYTE_W-1:0]         drv_data_out
);

  localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]          timer_q, timer_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [NUM_REQ-1:0]        done_q, done_d;
  logic [NUM_REQ-1:0]        err_q, err_d;
  logic [NUM_REQ-1:0]        cs_n_q, cs_n_d;
  logic [SPI_BYTE_W-1:0]     rx_data_q, rx_data_d;
  logic [SPI_BYTE_W-1:0]     drv_data_in_q, drv_data_in_d;
  logic                      drv_start_q, drv_start_d;

  logic [SPI_BYTE_W-1:0]     tx_byte [NUM_REQ];
  logic [IDX_W-1:0]          win_idx;
  logic                      win_valid;
  logic                      timed_out;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (win_idx),
    .valid  (win_valid)
  );

  // Split the flat TX bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tx_byte[i] = req_data[i*SPI_BYTE_W +: SPI_BYTE_W];
    end
  end

  assign timed_out = (timer_q == TMR_LAST);

  // Next-state and registered-output logic for the grant/handshake sequence.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    gnt_d         = gnt_q;
    done_d        = '0;
    err_d         = '0;
    rx_data_d     = rx_data_q;
    drv_data_in_d = drv_data_in_q;
    drv_start_d   = drv_start_q;
    // Chip select follows the registered grant and the driver's enable one cycle late.
    cs_n_d        = ~(gnt_q & {NUM_REQ{~drv_en}});

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (win_valid) begin
          owner_d          = win_idx;
          drv_data_in_d    = tx_byte[win_idx];
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          drv_start_d      = 1'b1;
          state_d          = START;
        end
      end
      START: begin
        if (!drv_en) begin
          drv_start_d = 1'b0;
          state_d     = BUSY;
        end else if (timed_out) begin
          err_d[owner_q] = 1'b1;
          gnt_d          = '0;
          drv_start_d    = 1'b0;
          state_d        = ERR;
        end
      end
      BUSY: begin
        // The driver clears data_out right after raising enable, so capture now.
        if (drv_en) begin
          rx_data_d       = drv_data_out;
          done_d[owner_q] = 1'b1;
          gnt_d           = '0;
          state_d         = DONE;
        end else if (timed_out) begin
          err_d[owner_q] = 1'b1;
          gnt_d          = '0;
          drv_start_d    = 1'b0;
          state_d        = ERR;
        end
      end
      DONE, ERR: begin
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      err_q         <= '0;
      cs_n_q        <= '1;
      rx_data_q     <= '0;
      drv_data_in_q <= '0;
      drv_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      err_q         <= err_d;
      cs_n_q        <= cs_n_d;
      rx_data_q     <= rx_data_d;
      drv_data_in_q <= drv_data_in_d;
      drv_start_q   <= drv_start_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign cs_n        = cs_n_q;
  assign rx_data     = rx_data_q;
  assign drv_data_in = drv_data_in_q;
  assign drv_start   = drv_start_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - self-checking bench for spi_arbiter with a transaction-level model
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic           clk          = 1'b0;
  logic           rst_n        = 1'b0;
  logic [N-1:0]   req          = '0;
  logic [N*8-1:0] req_data     = '0;
  logic [N-1:0]   gnt, done, err, cs_n;
  logic [7:0]     rx_data, drv_data_in;
  logic           drv_start;
  logic           drv_en       = 1'b1;
  logic [7:0]     drv_data_out = '0;

  logic           drv_hang = 1'b0;
  logic           drv_rand = 1'b1;
  logic [7:0]     drv_rx   = 8'h00;

  int checks = 0;
  int errors = 0;

  spi_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .rx_data      (rx_data),
    .cs_n         (cs_n),
    .drv_start    (drv_start),
    .drv_data_in  (drv_data_in),
    .drv_en       (drv_en),
    .drv_data_out (drv_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while ((done | err) == '0 && n < 400) begin
      step();
      n++;
    end
    check({name, "_arrived"}, 32'((done | err) != '0), 32'(1));
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!(gnt != '0 && !drv_start) && n < 200) begin
      step();
      n++;
    end
    check({name, "_busy"}, 32'(gnt != '0 && !drv_start), 32'(1));
  endtask

  // SPI driver: after seeing start, drops enable for a random time, then returns a byte for one cycle.
  initial begin : driver
    int ph;
    int cnt;
    ph  = 0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        drv_en       = 1'b1;
        drv_data_out = 8'h00;
        ph           = 0;
      end else begin
        case (ph)
          0: begin
            drv_en       = 1'b1;
            drv_data_out = 8'h00;
            if (drv_start && !drv_hang) begin
              cnt = $urandom_range(0, 2);
              ph  = 1;
            end
          end
          1: begin
            if (cnt == 0) begin
              drv_en = 1'b0;
              cnt    = $urandom_range(1, 10);
              ph     = 2;
            end else cnt--;
          end
          2: begin
            if (cnt == 0) begin
              drv_en       = 1'b1;
              drv_data_out = drv_rand ? 8'($urandom_range(0, 255)) : drv_rx;
              ph           = 3;
            end else cnt--;
          end
          default: begin
            drv_data_out = 8'h00;
            ph           = 0;
          end
        endcase
      end
    end
  end

  // Transaction-level reference: who owns the driver, whether it has acknowledged, how long we waited.
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_wait  = 0;
  bit           m_on    = 1'b0;
  bit           m_ack   = 1'b0;
  bit           m_gap   = 1'b0;
  logic [N-1:0] e_gnt   = '0;
  logic [N-1:0] e_done  = '0;
  logic [N-1:0] e_err   = '0;
  logic [N-1:0] e_cs    = '1;
  logic [7:0]   e_rx    = '0;
  logic [7:0]   e_din   = '0;
  logic         e_start = 1'b0;

  initial begin : model
    logic [N-1:0]   s_req;
    logic [N*8-1:0] s_data;
    logic           s_en, s_rst;
    logic [7:0]     s_dout;
    forever begin
      @(posedge clk);
      s_rst  = rst_n;
      s_req  = req;
      s_data = req_data;
      s_en   = drv_en;
      s_dout = drv_data_out;
      if (!s_rst) begin
        m_on    = 1'b1;
        m_owner = -1;
        m_ptr   = 0;
        m_gap   = 1'b0;
        e_gnt   = '0;
        e_done  = '0;
        e_err   = '0;
        e_cs    = '1;
        e_rx    = '0;
        e_din   = '0;
        e_start = 1'b0;
      end else if (m_on) begin
        e_cs   = ~(e_gnt & {N{~s_en}});
        e_done = '0;
        e_err  = '0;
        if (m_gap) begin
          m_gap = 1'b0;
        end else if (m_owner < 0) begin
          for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && ((s_req >> ((m_ptr + k) % N)) & 1) != 0) m_owner = (m_ptr + k) % N;
          end
          if (m_owner >= 0) begin
            e_gnt   = N'(1) << m_owner;
            e_din   = 8'(s_data >> (m_owner * 8));
            e_start = 1'b1;
            m_ack   = 1'b0;
            m_wait  = 0;
          end
        end else if (!m_ack && !s_en) begin
          m_ack   = 1'b1;
          e_start = 1'b0;
          m_wait  = 0;
        end else if (m_ack && s_en) begin
          e_rx    = s_dout;
          e_done  = N'(1) << m_owner;
          e_gnt   = '0;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = 1'b1;
        end else if (m_wait == TO - 1) begin
          e_err   = N'(1) << m_owner;
          e_gnt   = '0;
          e_start = 1'b0;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = 1'b1;
        end else begin
          m_wait++;
        end
      end
      #2;
      if (m_on) begin
        check("cyc_gnt", 32'(gnt), 32'(e_gnt));
        check("cyc_done", 32'(done), 32'(e_done));
        check("cyc_err", 32'(err), 32'(e_err));
        check("cyc_cs_n", 32'(cs_n), 32'(e_cs));
        check("cyc_rx_data", 32'(rx_data), 32'(e_rx));
        check("cyc_drv_data_in", 32'(drv_data_in), 32'(e_din));
        check("cyc_drv_start", 32'(drv_start), 32'(e_start));
        check("cyc_gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
      end
    end
  end

  initial begin : main
    int  n;
    bit  seen_cs;

    rst_n = 1'b0;
    repeat (3) step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_cs_n", 32'(cs_n), 32'hF);
    check("rst_drv_start", 32'(drv_start), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_done_err", 32'(done | err), 32'h0);
    check("rst_drv_data_in", 32'(drv_data_in), 32'h0);
    rst_n = 1'b1;

    // Single requester 2, TX 0xA5, driver returns 0x3C.
    drv_rand         = 1'b0;
    drv_rx           = 8'h3C;
    req_data[23:16]  = 8'hA5;
    req              = 4'b0100;
    step();
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_drv_data_in", 32'(drv_data_in), 32'hA5);
    check("t1_drv_start", 32'(drv_start), 32'h1);
    req     = 4'b0000;
    seen_cs = 1'b0;
    n       = 0;
    while (done == '0 && n < 200) begin
      step();
      n++;
      if (cs_n == 4'b1011) seen_cs = 1'b1;
    end
    check("t1_cs_low", 32'(seen_cs), 32'h1);
    check("t1_done", 32'(done), 32'h4);
    check("t1_rx_data", 32'(rx_data), 32'h3C);
    step();
    check("t1_cs_idle", 32'(cs_n), 32'hF);
    check("t1_done_gone", 32'(done), 32'h0);

    // Move the pointer to 0, then hold all requests for eight transfers.
    drv_rand = 1'b1;
    req      = 4'b1000;
    wait_end("t2_pre");
    check("t2_pre_done", 32'(done), 32'h8);
    req = 4'b1111;
    step();
    for (int i = 0; i < 8; i++) begin
      wait_end("t2_xfer");
      check("t2_order", 32'($clog2(done)), 32'(i % 4));
      if (i == 7) req = 4'b0000;
      step();
    end

    // Pointer to 2 via requester 1, then 1 and 3 together: 3 must win first.
    req = 4'b0010;
    wait_end("t3_pre");
    check("t3_pre_done", 32'(done), 32'h2);
    req = 4'b1010;
    step();
    step();
    check("t3_first_gnt", 32'(gnt), 32'h8);
    wait_end("t3_a");
    check("t3_first_done", 32'(done), 32'h8);
    step();
    wait_end("t3_b");
    check("t3_second_done", 32'(done), 32'h2);
    req = 4'b0000;
    step();

    // TX byte must not follow req_data once the transfer is under way.
    req_data[7:0] = 8'h11;
    req           = 4'b0001;
    wait_busy("t6");
    req_data[7:0] = 8'hFF;
    req           = 4'b0000;
    wait_end("t6");
    check("t6_done", 32'(done), 32'h1);
    check("t6_drv_data_in", 32'(drv_data_in), 32'h11);
    step();

    // Driver never answers: error after 64 START cycles, then the next requester is served.
    drv_hang = 1'b1;
    req      = 4'b0100;
    step();
    check("t4_gnt", 32'(gnt), 32'h4);
    n = 0;
    while (err == '0 && n < 200) begin
      step();
      n++;
    end
    check("t4_err_latency", 32'(n), 32'd64);
    check("t4_err", 32'(err), 32'h4);
    check("t4_gnt_clear", 32'(gnt), 32'h0);
    check("t4_drv_start", 32'(drv_start), 32'h0);
    drv_hang = 1'b0;
    req      = 4'b0011;
    step();
    wait_end("t4_next");
    check("t4_next_done", 32'(done), 32'h1);
    req = 4'b0000;
    step();

    // Reset in the middle of BUSY, then a fresh transfer.
    drv_rand = 1'b0;
    drv_rx   = 8'h77;
    req      = 4'b1000;
    wait_busy("t5");
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    check("t5_gnt", 32'(gnt), 32'h0);
    check("t5_cs_n", 32'(cs_n), 32'hF);
    check("t5_drv_start", 32'(drv_start), 32'h0);
    check("t5_rx_data", 32'(rx_data), 32'h0);
    rst_n  = 1'b1;
    drv_rx = 8'h5A;
    req    = 4'b0010;
    step();
    check("t5_fresh_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    wait_end("t5_fresh");
    check("t5_fresh_done", 32'(done), 32'h2);
    check("t5_fresh_rx", 32'(rx_data), 32'h5A);
    step();

    // Random traffic against the reference model.
    drv_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_data = 32'($urandom);
      if (!drv_hang && $urandom_range(0, 199) == 0) drv_hang = 1'b1;
      else if (drv_hang && $urandom_range(0, 29) == 0) drv_hang = 1'b0;
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    drv_hang = 1'b0;
    rst_n    = 1'b1;
    req      = '0;
    repeat (100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
